dline_seq_ctrl: RTL and testbench

//  Sequencer and 2-way arbiter for the byte-wide shift-register delay line. Two requesters

---
 rtl/dline_seq_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_dline_seq_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dline_seq_ctrl.sv
// dline_seq_ctrl: sequencer and round-robin 2-way arbiter for a shift-register delay line.
// Latency: a byte accepted on req0/req1 reaches the line output after DEPTH shifts; out_valid is registered.
// Backpressure: reqN_ready drops for the losing requester, during a flush request and while draining.
//
// Ports:
//   clk, rst                     clock (rising edge), asynchronous active-high reset
//   req0_valid/data/ready        requester 0 valid/ready handshake
//   req1_valid/data/ready        requester 1 valid/ready handshake
//   flush                        pulse: drain the line with zero bytes (ignored when idle)
//   sr_shift_en, sr_data_in      drive the external shift-register line
//   sr_data_out                  last stage of the line
//   out_valid, out_data, out_src real byte present at the line output, its value and source
//   occupancy                    number of real bytes inside the line
//   busy                         controller is not idle
//
// Optional feature: define DLSEQ_AUTOFLUSH_EN to start a drain automatically after
// TIMEOUT consecutive idle cycles in ACTIVE. Without it only the flush port drains.

module dline_seq_ctrl #(
    parameter int DEPTH   = 100,
    parameter int W       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0_valid,
    input  logic [W-1:0]               req0_data,
    output logic                       req0_ready,
    input  logic                       req1_valid,
    input  logic [W-1:0]               req1_data,
    output logic                       req1_ready,
    input  logic                       flush,
    output logic                       sr_shift_en,
    output logic [W-1:0]               sr_data_in,
    input  logic [W-1:0]               sr_data_out,
    output logic                       out_valid,
    output logic [W-1:0]               out_data,
    output logic                       out_src,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       busy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    if (DEPTH < 2 || TIMEOUT < 1) begin : g_param_check
        $error("dline_seq_ctrl: DEPTH must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    // Per-stage mirror of the line: which stages hold a real byte, and who sent it.
    logic [DEPTH-1:0]   tag_vld;
    logic [DEPTH-1:0]   tag_src;
    logic               last_grant;
    logic [OCC_W-1:0]   occ;
    logic [OCC_W-1:0]   occ_next;
    logic               out_valid_q;

    logic               grant0;
    logic               grant1;
    logic               fire0;
    logic               fire1;
    logic               fire;
    logic               shift;
    logic               auto_flush;

    // Ready is a function of valids, flush and state only, never of request data.
    always_comb begin
        grant0     = req0_valid & (~req1_valid | last_grant);
        grant1     = req1_valid & (~req0_valid | ~last_grant);
        req0_ready = grant0 & ~flush & (state != S_FLUSH);
        req1_ready = grant1 & ~flush & (state != S_FLUSH);
        fire0      = req0_valid & req0_ready;
        fire1      = req1_valid & req1_ready;
        fire       = fire0 | fire1;
    end

`ifdef DLSEQ_AUTOFLUSH_EN
    localparam int IDLE_W = $clog2(TIMEOUT+1);
    logic [IDLE_W-1:0] idle_cnt;

    // Fires on the TIMEOUT-th consecutive no-transfer cycle in ACTIVE. Using the
    // transfer result (not the flush-gated ready) keeps this free of a comb loop;
    // since no byte moves in that cycle, it behaves exactly like a flush pulse.
    assign auto_flush = (state == S_ACTIVE) && !fire && (idle_cnt == IDLE_W'(TIMEOUT-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (state != S_ACTIVE || fire || state_next != state) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign auto_flush = 1'b0;
`endif

    // Next state and line drive.
    always_comb begin
        state_next  = state;
        shift       = fire | (state == S_FLUSH);
        sr_shift_en = shift;
        sr_data_in  = '0;
        if (fire1) begin
            sr_data_in = req1_data;
        end else if (fire0) begin
            sr_data_in = req0_data;
        end

        // The last stage leaves the line on every shift; a new real byte enters only on a transfer.
        occ_next = occ;
        if (shift) begin
            occ_next = occ + OCC_W'(fire) - OCC_W'(tag_vld[DEPTH-1]);
        end

        case (state)
            S_IDLE: begin
                if (fire) begin
                    state_next = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (flush || auto_flush) begin
                    state_next = S_FLUSH;
                end else if (occ_next == '0) begin
                    state_next = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (occ_next == '0) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld     <= '0;
            tag_src     <= '0;
            last_grant  <= 1'b1;
            occ         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            occ <= occ_next;
            if (shift) begin
                tag_vld <= {tag_vld[DEPTH-2:0], fire};
                tag_src <= {tag_src[DEPTH-2:0], fire1};
            end
            if (fire) begin
                last_grant <= fire1;
            end
            // Stage DEPTH-2 becomes the last stage on this shift, so this flags a real
            // byte on sr_data_out for exactly the cycle after the shift.
            out_valid_q <= shift & tag_vld[DEPTH-2];
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = sr_data_out;
    assign out_src   = tag_src[DEPTH-1];
    assign occupancy = occ;
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_dline_seq_ctrl.sv
module tb_dline_seq_ctrl;

    localparam int DEPTH   = 4;
    localparam int W       = 8;
    localparam int TIMEOUT = 8;

    logic         clk;
    logic         rst;
    logic         req0_valid;
    logic [W-1:0] req0_data;
    logic         req0_ready;
    logic         req1_valid;
    logic [W-1:0] req1_data;
    logic         req1_ready;
    logic         flush;
    logic         sr_shift_en;
    logic [W-1:0] sr_data_in;
    logic [W-1:0] sr_data_out;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_src;
    logic [2:0]   occupancy;
    logic         busy;

    int nvec = 0;
    int nerr = 0;

    dline_seq_ctrl #(.DEPTH(DEPTH), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .flush       (flush),
        .sr_shift_en (sr_shift_en),
        .sr_data_in  (sr_data_in),
        .sr_data_out (sr_data_out),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_src     (out_src),
        .occupancy   (occupancy),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural delay line driven by the controller.
    logic [W-1:0] line_q [DEPTH];
    always @(posedge clk) begin
        if (sr_shift_en) begin
            line_q[0] <= sr_data_in;
            for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
        end
    end
    assign sr_data_out = line_q[DEPTH-1];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0;
        req0_data = '0; req1_data = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Round-robin stream byte j: even j from req0 (0x10..), odd j from req1 (0x20..).
    function automatic logic [7:0] rr_byte(input int j);
        logic [7:0] base;
        base = (j % 2 == 1) ? 8'h20 : 8'h10;
        return base + 8'(j / 2);
    endfunction

    task automatic test_reset();
        do_reset();
        rst = 1'b1; #1;
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
        nvec++; if (occupancy !== 3'd0) begin nerr++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        nvec++; if (sr_shift_en !== 1'b0) begin nerr++; $display("FAIL reset_shift_en: got %b want 0", sr_shift_en); end
        rst = 1'b0;
    endtask

    task automatic test_single_flush();
        req0_valid = 1'b1; req0_data = 8'hA5; #1;
        nvec++; if (req0_ready !== 1'b1) begin nerr++; $display("FAIL sf_ready0: got %b want 1", req0_ready); end
        nvec++; if (sr_shift_en !== 1'b1) begin nerr++; $display("FAIL sf_shift: got %b want 1", sr_shift_en); end
        nvec++; if (sr_data_in !== 8'hA5) begin nerr++; $display("FAIL sf_data_in: got %h want a5", sr_data_in); end
        tick();
        req0_valid = 1'b0; req0_data = '0;
        nvec++; if (occupancy !== 3'd1) begin nerr++; $display("FAIL sf_occ1: got %0d want 1", occupancy); end
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL sf_busy: got %b want 1", busy); end
        flush = 1'b1; #1;
        nvec++; if (sr_shift_en !== 1'b0) begin nerr++; $display("FAIL sf_flush_noshift: got %b want 0", sr_shift_en); end
        tick();
        flush = 1'b0; #1;
        nvec++; if (sr_shift_en !== 1'b1) begin nerr++; $display("FAIL sf_drain_shift: got %b want 1", sr_shift_en); end
        nvec++; if (sr_data_in !== 8'h00) begin nerr++; $display("FAIL sf_drain_data: got %h want 00", sr_data_in); end
        tick(); tick();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL sf_early_valid: got %b want 0", out_valid); end
        tick();
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL sf_out_valid: got %b want 1", out_valid); end
        nvec++; if (out_data !== 8'hA5) begin nerr++; $display("FAIL sf_out_data: got %h want a5", out_data); end
        nvec++; if (out_src !== 1'b0) begin nerr++; $display("FAIL sf_out_src: got %b want 0", out_src); end
        nvec++; if (occupancy !== 3'd1) begin nerr++; $display("FAIL sf_occ_before_exit: got %0d want 1", occupancy); end
        tick();
        nvec++; if (occupancy !== 3'd0) begin nerr++; $display("FAIL sf_occ_end: got %0d want 0", occupancy); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL sf_idle: got %b want 0", busy); end
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL sf_valid_end: got %b want 0", out_valid); end
    endtask

    task automatic test_round_robin();
        int n0 = 0;
        int n1 = 0;
        logic g1;
        int exp_occ;
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req0_data = 8'h10 + 8'(n0);
            req1_data = 8'h20 + 8'(n1);
            #1;
            g1 = (k % 2 == 1);
            nvec++; if (req0_ready !== !g1) begin nerr++; $display("FAIL rr_ready0[%0d]: got %b want %b", k, req0_ready, !g1); end
            nvec++; if (req1_ready !== g1) begin nerr++; $display("FAIL rr_ready1[%0d]: got %b want %b", k, req1_ready, g1); end
            nvec++; if (sr_data_in !== rr_byte(k)) begin nerr++; $display("FAIL rr_data_in[%0d]: got %h want %h", k, sr_data_in, rr_byte(k)); end
            tick();
            if (g1) n1++; else n0++;
            exp_occ = (k + 1 > 4) ? 4 : k + 1;
            nvec++; if (occupancy !== 3'(exp_occ)) begin nerr++; $display("FAIL rr_occ[%0d]: got %0d want %0d", k, occupancy, exp_occ); end
            nvec++; if (out_valid !== (k >= 3)) begin nerr++; $display("FAIL rr_out_valid[%0d]: got %b want %b", k, out_valid, (k >= 3)); end
            if (k >= 3) begin
                nvec++; if (out_src !== 1'((k - 3) % 2)) begin nerr++; $display("FAIL rr_out_src[%0d]: got %b want %0d", k, out_src, (k - 3) % 2); end
                nvec++; if (out_data !== rr_byte(k - 3)) begin nerr++; $display("FAIL rr_out_data[%0d]: got %h want %h", k, out_data, rr_byte(k - 3)); end
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rr_static_valid: got %b want 0", out_valid); end
        nvec++; if (occupancy !== 3'd4) begin nerr++; $display("FAIL rr_static_occ: got %0d want 4", occupancy); end
    endtask

    // Continues from the saturated round-robin line (bytes 4..7 inside, last grant req1).
    task automatic test_flush_vs_request();
        req1_valid = 1'b1; req1_data = 8'h77; flush = 1'b1; #1;
        nvec++; if (req1_ready !== 1'b0) begin nerr++; $display("FAIL fr_ready_flush: got %b want 0", req1_ready); end
        nvec++; if (sr_shift_en !== 1'b0) begin nerr++; $display("FAIL fr_shift_flush: got %b want 0", sr_shift_en); end
        tick();
        flush = 1'b0;
        for (int s = 0; s < 4; s++) begin
            #1;
            nvec++; if (req1_ready !== 1'b0) begin nerr++; $display("FAIL fr_ready_drain[%0d]: got %b want 0", s, req1_ready); end
            nvec++; if (sr_data_in !== 8'h00) begin nerr++; $display("FAIL fr_drain_data[%0d]: got %h want 00", s, sr_data_in); end
            tick();
            nvec++; if (occupancy !== 3'(3 - s)) begin nerr++; $display("FAIL fr_occ[%0d]: got %0d want %0d", s, occupancy, 3 - s); end
            if (s < 3) begin
                nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL fr_out_valid[%0d]: got %b want 1", s, out_valid); end
                nvec++; if (out_data !== rr_byte(5 + s)) begin nerr++; $display("FAIL fr_out_data[%0d]: got %h want %h", s, out_data, rr_byte(5 + s)); end
                nvec++; if (out_src !== 1'((5 + s) % 2)) begin nerr++; $display("FAIL fr_out_src[%0d]: got %b want %0d", s, out_src, (5 + s) % 2); end
            end
        end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL fr_idle: got %b want 0", busy); end
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL fr_valid_end: got %b want 0", out_valid); end
        #1;
        nvec++; if (req1_ready !== 1'b1) begin nerr++; $display("FAIL fr_ready_idle: got %b want 1", req1_ready); end
        nvec++; if (sr_data_in !== 8'h77) begin nerr++; $display("FAIL fr_data_idle: got %h want 77", sr_data_in); end
        tick();
        req1_valid = 1'b0;
        nvec++; if (occupancy !== 3'd1) begin nerr++; $display("FAIL fr_occ_after: got %0d want 1", occupancy); end
    endtask

    task automatic test_stream();
        int exp_occ;
        do_reset();
        req0_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req0_data = 8'(k + 1); #1;
            nvec++; if (req0_ready !== 1'b1) begin nerr++; $display("FAIL st_ready[%0d]: got %b want 1", k, req0_ready); end
            tick();
            exp_occ = (k + 1 > 4) ? 4 : k + 1;
            nvec++; if (occupancy !== 3'(exp_occ)) begin nerr++; $display("FAIL st_occ[%0d]: got %0d want %0d", k, occupancy, exp_occ); end
            nvec++; if (out_valid !== (k >= 3)) begin nerr++; $display("FAIL st_out_valid[%0d]: got %b want %b", k, out_valid, (k >= 3)); end
            if (k >= 3) begin
                nvec++; if (out_data !== 8'(k - 2)) begin nerr++; $display("FAIL st_out_data[%0d]: got %h want %h", k, out_data, 8'(k - 2)); end
            end
        end
        req0_valid = 1'b0;
        tick();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL st_noshift_valid: got %b want 0", out_valid); end
        nvec++; if (occupancy !== 3'd4) begin nerr++; $display("FAIL st_occ_hold: got %0d want 4", occupancy); end
        nvec++; if (out_data !== 8'h03) begin nerr++; $display("FAIL st_data_hold: got %h want 03", out_data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req0_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req0_data = 8'h30 + 8'(k);
            tick();
        end
        req0_valid = 1'b0;
        nvec++; if (occupancy !== 3'd3) begin nerr++; $display("FAIL rm_occ_pre: got %0d want 3", occupancy); end
        rst = 1'b1; #1;
        nvec++; if (occupancy !== 3'd0) begin nerr++; $display("FAIL rm_occ: got %0d want 0", occupancy); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rm_busy: got %b want 0", busy); end
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rm_out_valid: got %b want 0", out_valid); end
        tick();
        rst = 1'b0;
        // Before reset req0 was granted last; reset must restore req0-first priority.
        req0_valid = 1'b1; req1_valid = 1'b1; #1;
        nvec++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin nerr++; $display("FAIL rm_first_grant: got %b%b want 10", req0_ready, req1_ready); end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_autoflush();
        do_reset();
        req0_valid = 1'b1; req0_data = 8'hC3;
        tick();
        req0_valid = 1'b0;
`ifdef DLSEQ_AUTOFLUSH_EN
        for (int i = 0; i < 7; i++) tick();
        #1;
        nvec++; if (sr_shift_en !== 1'b0) begin nerr++; $display("FAIL af_no_early_flush: got %b want 0", sr_shift_en); end
        tick(); #1;
        nvec++; if (sr_shift_en !== 1'b1) begin nerr++; $display("FAIL af_flush_entered: got %b want 1", sr_shift_en); end
        tick(); tick(); tick();
        nvec++; if (out_valid !== 1'b1 || out_data !== 8'hC3) begin nerr++; $display("FAIL af_out: got %b/%h want 1/c3", out_valid, out_data); end
        tick();
        nvec++; if (busy !== 1'b0 || occupancy !== 3'd0) begin nerr++; $display("FAIL af_idle: got busy %b occ %0d want 0/0", busy, occupancy); end
`else
        for (int i = 0; i < 20; i++) tick();
        #1;
        nvec++; if (sr_shift_en !== 1'b0) begin nerr++; $display("FAIL af_no_flush: got %b want 0", sr_shift_en); end
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL af_stays_active: got %b want 1", busy); end
        nvec++; if (occupancy !== 3'd1) begin nerr++; $display("FAIL af_occ: got %0d want 1", occupancy); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0;
        req0_data = '0; req1_data = '0;
        test_reset();
        test_single_flush();
        test_round_robin();
        test_flush_vs_request();
        test_stream();
        test_reset_mid();
        test_autoflush();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
